// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: FSM states, the BCD to
// 7-segment table, decimal-point placement and per-digit rollover limits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_LAP  = 2'd3
    } sw_state_t;

    localparam int NUM_DIGITS = 6;

    // Segment patterns for 0..9, bit order g..a, 1 = lit
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Digit index 0 = centiseconds ones (rightmost) ... 5 = minutes tens
    localparam int DP_POS_SEC = 2;
    localparam int DP_POS_MIN = 4;
    localparam logic [NUM_DIGITS-1:0] DP_MASK =
        NUM_DIGITS'((1 << DP_POS_SEC) | (1 << DP_POS_MIN));

    // Tens-of-seconds and tens-of-minutes roll over after 5
    function automatic logic [3:0] digit_max(input int idx);
        if (idx == 3 || idx == 5) begin
            return 4'd5;
        end
        return 4'd9;
    endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Button and display bundle between a stopwatch front panel and the core.
interface stopwatch_core_if;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic [7:0] segout1;
    logic [7:0] segout2;
    logic [7:0] segout3;
    logic [7:0] segout4;
    logic [7:0] segout5;
    logic [7:0] segout6;
    logic       running;
    logic       lap_active;
    logic       wrap;

    modport master (
        output start_stop, lap, clear,
        input  segout1, segout2, segout3, segout4, segout5, segout6,
        input  running, lap_active, wrap
    );

    modport slave (
        input  start_stop, lap, clear,
        output segout1, segout2, segout3, segout4, segout5, segout6,
        output running, lap_active, wrap
    );
endinterface

// File: rtl/seg7_encode.sv
// Purely combinational BCD digit to 7-segment pattern; non-decimal codes blank.
module seg7_encode
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        if (bcd <= 4'd9) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS.cc stopwatch: button edge detection, run/stop/lap FSM, tick prescaler,
// BCD ripple counter with lap snapshot, and registered 7-segment outputs.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       i_sclk,
    input  logic       i_reset,
    input  logic       i_start_stop,
    input  logic       i_lap,
    input  logic       i_clear,
    output logic [7:0] o_segout1,
    output logic [7:0] o_segout2,
    output logic [7:0] o_segout3,
    output logic [7:0] o_segout4,
    output logic [7:0] o_segout5,
    output logic [7:0] o_segout6,
    output logic       o_running,
    output logic       o_lap_active,
    output logic       o_wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    sw_state_t state_reg;
    sw_state_t state_next;

    logic start_prev_reg;
    logic lap_prev_reg;
    logic clear_prev_reg;
    logic armed_reg;

    logic [PW-1:0] presc_reg;
    logic [NUM_DIGITS-1:0][3:0] digit_reg;
    logic [NUM_DIGITS-1:0][3:0] digit_next;
    logic [NUM_DIGITS-1:0][3:0] snap_reg;
    logic [NUM_DIGITS-1:0][3:0] disp_src;
    logic [NUM_DIGITS-1:0][6:0] seg_pat;
    logic [NUM_DIGITS-1:0][7:0] seg_reg;
    logic wrap_reg;

    logic start_rise;
    logic lap_rise;
    logic clear_rise;
    logic counting;
    logic tick;
    logic wrap_now;
    logic clear_act;
    logic snap_act;

    // armed_reg stays low for the first cycle after reset so a button that
    // was already held while reset was asserted never looks like a new press.
    assign start_rise = armed_reg & i_start_stop & ~start_prev_reg;
    assign lap_rise   = armed_reg & i_lap        & ~lap_prev_reg;
    assign clear_rise = armed_reg & i_clear      & ~clear_prev_reg;

    assign counting = (state_reg == ST_RUN) || (state_reg == ST_LAP);
    assign tick     = counting && (presc_reg == PRESC_LAST);

    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Commands a state does not accept are dropped before priority applies,
    // so clear+start_stop in RUN still stops the count.
    always_comb begin
        state_next = state_reg;
        clear_act  = 1'b0;
        snap_act   = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (clear_rise) begin
                    clear_act = 1'b1;
                end else if (start_rise) begin
                    state_next = ST_RUN;
                end
            end
            ST_STOP: begin
                if (clear_rise) begin
                    state_next = ST_IDLE;
                    clear_act  = 1'b1;
                end else if (start_rise) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start_rise) begin
                    state_next = ST_STOP;
                end else if (lap_rise) begin
                    state_next = ST_LAP;
                    snap_act   = 1'b1;
                end
            end
            ST_LAP: begin
                if (start_rise) begin
                    state_next = ST_STOP;
                end else if (lap_rise) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin : ripple
        logic carry;
        carry = tick;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_next[i] = digit_reg[i];
            if (carry) begin
                if (digit_reg[i] == digit_max(i)) begin
                    digit_next[i] = 4'd0;
                end else begin
                    digit_next[i] = digit_reg[i] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        wrap_now = carry;
    end

    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            start_prev_reg <= 1'b0;
            lap_prev_reg   <= 1'b0;
            clear_prev_reg <= 1'b0;
            armed_reg      <= 1'b0;
            presc_reg      <= '0;
            digit_reg      <= '0;
            snap_reg       <= '0;
            wrap_reg       <= 1'b0;
        end else begin
            start_prev_reg <= i_start_stop;
            lap_prev_reg   <= i_lap;
            clear_prev_reg <= i_clear;
            armed_reg      <= 1'b1;
            wrap_reg       <= wrap_now;
            if (clear_act) begin
                presc_reg <= '0;
                digit_reg <= '0;
            end else if (counting) begin
                presc_reg <= tick ? '0 : presc_reg + PW'(1);
                digit_reg <= digit_next;
            end
            if (snap_act) begin
                snap_reg <= digit_reg;
            end
        end
    end

    assign disp_src = (state_reg == ST_LAP) ? snap_reg : digit_reg;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            seg7_encode u_enc (
                .bcd (disp_src[gi]),
                .seg (seg_pat[gi])
            );

            always_ff @(posedge i_sclk) begin
                if (i_reset) begin
                    seg_reg[gi] <= {DP_MASK[gi], SEG_TABLE[0]};
                end else begin
                    seg_reg[gi] <= {DP_MASK[gi], seg_pat[gi]};
                end
            end
        end
    endgenerate

    assign o_segout1    = seg_reg[0];
    assign o_segout2    = seg_reg[1];
    assign o_segout3    = seg_reg[2];
    assign o_segout4    = seg_reg[3];
    assign o_segout5    = seg_reg[4];
    assign o_segout6    = seg_reg[5];
    assign o_running    = counting;
    assign o_lap_active = (state_reg == ST_LAP);
    assign o_wrap       = wrap_reg;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core at 1 kHz clock / 100 Hz tick: fixed vector table,
// directed wrap and reset-in-lap sequences, and random button traffic.
module tb_stopwatch_core;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int FULL    = 360000;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;
    localparam int M_LAP  = 3;

    logic clk = 1'b0;
    logic rst;
    stopwatch_core_if bus ();

    always #5 clk = ~clk;

    stopwatch_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
        .i_sclk       (clk),
        .i_reset      (rst),
        .i_start_stop (bus.start_stop),
        .i_lap        (bus.lap),
        .i_clear      (bus.clear),
        .o_segout1    (bus.segout1),
        .o_segout2    (bus.segout2),
        .o_segout3    (bus.segout3),
        .o_segout4    (bus.segout4),
        .o_segout5    (bus.segout5),
        .o_segout6    (bus.segout6),
        .o_running    (bus.running),
        .o_lap_active (bus.lap_active),
        .o_wrap       (bus.wrap)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: elapsed time as a plain centisecond count
    int m_state = M_IDLE;
    int m_cs    = 0;
    int m_pre   = 0;
    int m_snap  = 0;
    int m_disp  = 0;
    bit m_wrap  = 0;
    bit m_armed = 0;
    bit m_prev_ss = 0, m_prev_lp = 0, m_prev_cl = 0;

    function automatic logic [7:0] exp_seg(input int pos, input int v);
        int mins, secs, cs, d;
        logic [6:0] p;
        mins = v / 6000;
        secs = (v / 100) % 60;
        cs   = v % 100;
        case (pos)
            1: d = cs % 10;
            2: d = cs / 10;
            3: d = secs % 10;
            4: d = secs / 10;
            5: d = mins % 10;
            default: d = mins / 10;
        endcase
        case (d)
            0: p = 7'h3F;  1: p = 7'h06;  2: p = 7'h5B;  3: p = 7'h4F;
            4: p = 7'h66;  5: p = 7'h6D;  6: p = 7'h7D;  7: p = 7'h07;
            8: p = 7'h7F;  default: p = 7'h6F;
        endcase
        return {(pos == 3 || pos == 5), p};
    endfunction

    function automatic logic [47:0] exp_all(input int v);
        return {exp_seg(6, v), exp_seg(5, v), exp_seg(4, v),
                exp_seg(3, v), exp_seg(2, v), exp_seg(1, v)};
    endfunction

    function automatic logic [47:0] act_all();
        return {bus.segout6, bus.segout5, bus.segout4,
                bus.segout3, bus.segout2, bus.segout1};
    endfunction

    function automatic void model_edge(input bit ss, input bit lp, input bit cl, input bit rs);
        int  src_old, ns, new_cs, new_pre;
        bit  r_ss, r_lp, r_cl;
        if (rs) begin
            m_state = M_IDLE; m_cs = 0; m_pre = 0; m_snap = 0; m_disp = 0;
            m_wrap = 0; m_armed = 0; m_prev_ss = 0; m_prev_lp = 0; m_prev_cl = 0;
            return;
        end
        src_old = (m_state == M_LAP) ? m_snap : m_cs;
        r_ss = m_armed && ss && !m_prev_ss;
        r_lp = m_armed && lp && !m_prev_lp;
        r_cl = m_armed && cl && !m_prev_cl;
        new_cs = m_cs; new_pre = m_pre; ns = m_state; m_wrap = 0;
        if (m_state == M_RUN || m_state == M_LAP) begin
            if (m_pre == DIV - 1) begin
                new_pre = 0;
                m_wrap  = (m_cs == FULL - 1);
                new_cs  = (m_cs + 1) % FULL;
            end else begin
                new_pre = m_pre + 1;
            end
        end
        case (m_state)
            M_IDLE: if (r_cl) begin new_cs = 0; new_pre = 0; end
                    else if (r_ss) ns = M_RUN;
            M_STOP: if (r_cl) begin ns = M_IDLE; new_cs = 0; new_pre = 0; end
                    else if (r_ss) ns = M_RUN;
            M_RUN:  if (r_ss) ns = M_STOP;
                    else if (r_lp) begin ns = M_LAP; m_snap = m_cs; end
            default: if (r_ss) ns = M_STOP;
                     else if (r_lp) ns = M_RUN;
        endcase
        m_disp = src_old;
        m_state = ns; m_cs = new_cs; m_pre = new_pre;
        m_prev_ss = ss; m_prev_lp = lp; m_prev_cl = cl; m_armed = 1;
    endfunction

    task automatic check_model();
        logic [47:0] e, a;
        bit er, el;
        e  = exp_all(m_disp);
        a  = act_all();
        er = (m_state == M_RUN || m_state == M_LAP);
        el = (m_state == M_LAP);
        n_vec++;
        if (a !== e || bus.running !== er || bus.lap_active !== el || bus.wrap !== m_wrap) begin
            n_bad++;
            $display("FAIL model t=%0t: segs=%h run=%b lap=%b wrap=%b, want segs=%h run=%b lap=%b wrap=%b",
                     $time, a, bus.running, bus.lap_active, bus.wrap, e, er, el, m_wrap);
        end
    endtask

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge
    task automatic step(input bit rs, input bit ss, input bit lp, input bit cl);
        rst = rs; bus.start_stop = ss; bus.lap = lp; bus.clear = cl;
        @(posedge clk);
        model_edge(ss, lp, cl, rs);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit rs, ss, lp, cl;
        int idle_n;
        bit exp_run, exp_lap;
        int exp_cs;
    } vec_t;

    vec_t vt [13];

    initial begin
        int wraps, after_wrap;
        rst = 1'b1; bus.start_stop = 1'b0; bus.lap = 1'b0; bus.clear = 1'b0;

        //          rs ss lp cl idle  run lap  cs
        vt[0]  = '{1, 0, 0, 0,   50,  0, 0,    0};  // reset then idle
        vt[1]  = '{0, 1, 0, 0, 1001,  1, 0,  100};  // run to 00:01.00
        vt[2]  = '{0, 0, 1, 0,  299,  1, 1,  100};  // lap: frozen display
        vt[3]  = '{0, 0, 1, 0,    1,  1, 0,  130};  // lap again: live 01.30
        vt[4]  = '{0, 1, 0, 0,   20,  0, 0,  130};  // stop
        vt[5]  = '{0, 1, 0, 1,    5,  0, 0,    0};  // clear beats start in STOP
        vt[6]  = '{0, 1, 0, 0,   25,  1, 0,    2};  // restart from zero
        vt[7]  = '{0, 1, 0, 1,    3,  0, 0,    2};  // clear ignored in RUN
        vt[8]  = '{0, 0, 1, 0,    3,  0, 0,    2};  // lap ignored in STOP
        vt[9]  = '{0, 0, 0, 1,    2,  0, 0,    0};  // clear to IDLE
        vt[10] = '{0, 0, 1, 0,    2,  0, 0,    0};  // lap ignored in IDLE
        vt[11] = '{0, 1, 0, 0,    0,  1, 0,    0};  // running next cycle
        vt[12] = '{0, 0, 0, 1,   12,  1, 0,    1};  // clear ignored, keeps counting

        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            step(vt[i].rs, vt[i].ss, vt[i].lp, vt[i].cl);
            idle(vt[i].idle_n);
            check_eq($sformatf("vec%0d", i),
                     {14'd0, act_all(), bus.running, bus.lap_active},
                     {14'd0, exp_all(vt[i].exp_cs), vt[i].exp_run, vt[i].exp_lap});
            $display("vec %0d: segs=%h run=%b lap=%b", i, act_all(), bus.running, bus.lap_active);
        end

        // Rollover from 59:59.98 while running
        step(1, 0, 0, 0); idle(3); step(0, 1, 0, 0); idle(4);
        force dut.digit_reg = 24'h595998;
        m_cs = 359998;
        #1 release dut.digit_reg;
        wraps = 0; after_wrap = 0;
        for (int i = 0; i < 30; i++) begin
            idle(1);
            if (after_wrap == 1) begin
                check_eq("wrap_display", {16'd0, act_all()}, {16'd0, exp_all(0)});
                check_eq("wrap_running", {63'd0, bus.running}, 64'd1);
            end
            if (after_wrap > 0) after_wrap++;
            if (bus.wrap === 1'b1) begin wraps++; after_wrap = 1; end
        end
        check_eq("wrap_pulses", 64'(wraps), 64'd1);
        $display("wrap seq: pulses=%0d", wraps);

        // Reset during LAP with buttons held through deassertion
        step(1, 0, 0, 0); idle(2); step(0, 1, 0, 0); idle(57); step(0, 0, 1, 0); idle(10);
        check_eq("lap_before_reset", {63'd0, bus.lap_active}, 64'd1);
        step(1, 1, 1, 0); step(1, 1, 1, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 1, 0);
        check_eq("held_through_reset", {14'd0, act_all(), bus.running, bus.lap_active},
                 {14'd0, exp_all(0), 1'b0, 1'b0});
        idle(3); step(0, 1, 0, 0);
        check_eq("press_after_reset", {63'd0, bus.running}, 64'd1);
        $display("reset-in-lap seq: run=%b lap=%b", bus.running, bus.lap_active);

        // Random button traffic against the model
        for (int t = 0; t < 150; t++) begin
            bit ss, lp, cl, rs;
            int len;
            ss  = ($urandom_range(0, 2) == 0);
            lp  = ($urandom_range(0, 2) == 0);
            cl  = ($urandom_range(0, 4) == 0);
            rs  = ($urandom_range(0, 30) == 0);
            len = $urandom_range(1, 40);
            step(rs, ss, lp, cl);
            for (int i = 1; i < len; i++) step(1'b0, ss, lp, cl);
            $display("txn %0d: ss=%b lap=%b clr=%b rst=%b len=%0d -> run=%b lap=%b segs=%h",
                     t, ss, lp, cl, rs, len, bus.running, bus.lap_active, act_all());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
